// File: rtl/point_fetch_unit_pkg.sv
// Shared constants and types for the point fetch engine.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package point_fetch_unit_pkg;

   // AXI read-address fixed fields and response codes
   localparam logic [2:0] ARSIZE_8B  = 3'd3;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   // One point is one 64-bit beat; byte address advances by 8 per point
   localparam int POINT_W  = 64;
   localparam int PT_SHIFT = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/point_fetch_unit_fifo.sv
// Synchronous first-word-fall-through FIFO holding fetched points.
// Latency: a word pushed at edge t is at the head (dout_o/valid_o) after edge t.
// Backpressure: pop when empty is ignored; writer must respect full_o/count_o.
module point_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [DATA_W-1:0]        din_i,
   output logic [DATA_W-1:0]        dout_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_q, rd_q;
   logic [PTR_W:0]    cnt_q;
   logic              do_push, do_pop;

   assign valid_o = (cnt_q != '0);
   assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
   assign count_o = cnt_q;
   assign do_pop  = pop_i & valid_o;
   // A push into a full FIFO is only legal when a pop frees the slot the same cycle
   assign do_push = push_i & (~full_o | do_pop);
   // Head is masked so the output reads zero while nothing is stored
   assign dout_o  = valid_o ? mem_q[rd_q] : '0;

   // Storage array; contents need no reset because valid_o masks the head
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   // Pointers and occupancy; simultaneous push and pop leaves the count unchanged
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/point_fetch_unit.sv
// Fetches a batch of 64-bit points from DDR with AXI4 INCR bursts into a FWFT buffer.
// Latency: a beat accepted on R at edge t is visible on o_point at t+1; done is registered out of DONE.
// Backpressure: AR is held back until the buffer can absorb the whole burst, so R is never stalled.
module point_fetch_unit
   import point_fetch_unit_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = POINT_W,
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_init_read,
   input  logic [ADDR_W-1:0]             i_read_address,
   input  logic [31:0]                   i_n_points,
   output logic                          o_read_txn_done,
   output logic                          o_busy,
   output logic                          o_error,
   output logic [ADDR_W-1:0]             o_araddr,
   output logic [7:0]                    o_arlen,
   output logic                          o_arvalid,
   input  logic                          i_arready,
   input  logic [DATA_W-1:0]             i_rdata,
   input  logic [1:0]                    i_rresp,
   input  logic                          i_rlast,
   input  logic                          i_rvalid,
   output logic                          o_rready,
   output logic [DATA_W-1:0]             o_point,
   output logic                          o_point_valid,
   input  logic                          i_point_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
   localparam int LEN_W = 9;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         rem_q, rem_d;
   logic [LEN_W-1:0]    beat_q, beat_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [LEN_W-1:0]    len, beat_nxt;
   logic                push, space_ok, fifo_full;

   // Current burst length: full bursts until the tail of the batch
   assign len      = (rem_q >= 32'(BURST_LEN)) ? LEN_W'(BURST_LEN) : rem_q[LEN_W-1:0];
   assign beat_nxt = beat_q + 1'b1;
   // Count can only fall while waiting in ADDR, so AR stays asserted once raised
   assign space_ok = ~fifo_full &&
                     ((32'(o_fifo_count) + 32'(len)) <= 32'(FIFO_DEPTH));

   assign o_araddr        = addr_q;
   assign o_arlen         = (state_q == ST_ADDR) ? 8'(len - 1'b1) : 8'd0;
   assign o_busy          = busy_q;
   assign o_error         = err_q;
   assign o_read_txn_done = done_q;

   // Next-state, counters and error detection for the batch sequencer
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      beat_d    = beat_q;
      err_d     = err_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      o_arvalid = 1'b0;
      o_rready  = 1'b0;
      push      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_init_read) begin
               addr_d  = {i_read_address[ADDR_W-1:PT_SHIFT], {PT_SHIFT{1'b0}}};
               rem_d   = i_n_points;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = (i_n_points == 32'd0) ? ST_DONE : ST_ADDR;
            end
         end
         ST_ADDR: begin
            o_arvalid = space_ok;
            if (space_ok && i_arready) begin
               beat_d  = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            o_rready = 1'b1;
            if (i_rvalid) begin
               push   = 1'b1;
               beat_d = beat_nxt;
               if (i_rresp != RESP_OKAY) err_d = 1'b1;
               // rlast must coincide exactly with the len-th beat
               if (i_rlast != (beat_nxt == len)) err_d = 1'b1;
               if (i_rlast) begin
                  addr_d  = addr_q + (ADDR_W'(len) << PT_SHIFT);
                  rem_d   = rem_q - 32'(len);
                  beat_d  = '0;
                  state_d = (rem_q == 32'(len)) ? ST_DONE : ST_ADDR;
               end
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any in-flight transaction
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   point_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (i_clk),
      .rst_ni  (i_rst),
      .push_i  (push),
      .pop_i   (i_point_ready),
      .din_i   (i_rdata),
      .dout_o  (o_point),
      .valid_o (o_point_valid),
      .count_o (o_fifo_count),
      .full_o  (fifo_full)
   );

endmodule
